// File: rtl/iter_sfu.sv
// -----------------------------------------------------------------------------
// iter_sfu -- iterative bit-serial shift unit
//
// Performs a 32-bit logical-left, logical-right or arithmetic-right shift one
// bit position per clock. An accepted request takes shamt+2 cycles to finish.
// The result is presented on c together with a one-cycle done pulse.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  request, sampled only while idle
//   flush    in   1  synchronous abort of an in-flight operation
//   a        in  32  operand to shift
//   b        in  32  shift amount (only b[4:0] used)
//   control  in   2  00 sll, 01 srl, 11 sra, 10 illegal
//   c        out 32  registered result, changes only when an op completes
//   busy     out  1  operation in flight
//   done     out  1  one-cycle pulse marking c valid
//   err      out  1  with done: the completed op was illegal
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module iter_sfu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  control,
    output logic [31:0] c,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;
    localparam logic [1:0] OP_ILL = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] work_q,  work_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  op_q,    op_d;
    logic [31:0] c_q,     c_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;
    logic        busy_q,  busy_d;
    logic [31:0] shifted;

    // One-position shift of the work register for the latched operation.
    always_comb begin
        shifted = work_q;
        case (op_q)
            OP_SLL:  shifted = {work_q[30:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[31:1]};
            OP_SRA:  shifted = {work_q[31], work_q[31:1]};
            default: shifted = work_q;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        c_d     = c_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // flush has priority over start even when idle
                if (start && !flush) begin
                    work_d  = a;
                    count_d = b[4:0];
                    op_d    = control;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (op_q == OP_ILL || count_q == 5'd0) begin
                    // Illegal ops skip shifting entirely.
                    state_d = FIN;
                end else begin
                    work_d  = shifted;
                    count_d = count_q - 5'd1;
                end
            end
            FIN: begin
                // start is not looked at here; only IDLE accepts requests.
                state_d = IDLE;
                if (!flush) begin
                    c_d    = (op_q == OP_ILL) ? 32'h0000_0000 : work_q;
                    done_d = 1'b1;
                    err_d  = (op_q == OP_ILL);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 32'h0000_0000;
            count_q <= 5'd0;
            op_q    <= OP_SLL;
            c_q     <= 32'h0000_0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
            c_q     <= c_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign c    = c_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_iter_sfu.sv
`timescale 1ns/100ps
module tb_iter_sfu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  control = '0;
    logic [31:0] c;
    logic        busy, done, err;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] last_c = 32'h0;

    iter_sfu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .a       (a),
        .b       (b),
        .control (control),
        .c       (c),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to completion.
    // inject: pulse start with other operands while busy.
    // fin_start: hold start high during the FIN cycle.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] cv, input logic [31:0] exp_c,
                          input bit inject, input bit fin_start);
        int lat, e, nbusy;
        bit seen;
        lat = (cv == 2'b10) ? 2 : int'(bv[4:0]) + 2;
        @(negedge clk);
        a = av; b = bv; control = cv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0000_001F; control = 2'b10;
        e = 0; nbusy = 0; seen = 1'b0;
        while (e < 40) begin
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (inject && e == 1) || (fin_start && e == lat - 1);
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(e), 32'(lat));
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'(lat));
        chk({tag, " c"}, c, exp_c);
        chk({tag, " err"}, 32'(err), 32'(cv == 2'b10));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_drop"}, 32'(done), 32'd0);
        chk({tag, " err_drop"}, 32'(err), 32'd0);
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        last_c = exp_c;
        $display("op %s a=%h b=%h ctl=%b c=%h lat=%0d", tag, av, bv, cv, c, e);
    endtask

    initial begin
        int e;
        int ndone;

        // Reset state, checked while reset is asserted
        #1;
        chk("rst c", c, 32'h0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sll1_4",   32'h0000_0001, 32'd4,          2'b00, 32'h0000_0010, 1'b0, 1'b0);
        run_op("sra_31",   32'h8000_0000, 32'd31,         2'b11, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("srl_31",   32'h8000_0000, 32'd31,         2'b01, 32'h0000_0001, 1'b0, 1'b0);
        run_op("srl_b25",  32'hF000_0000, 32'h0000_0025,  2'b01, 32'h0780_0000, 1'b0, 1'b0);
        run_op("sll_0",    32'h1234_5678, 32'd0,          2'b00, 32'h1234_5678, 1'b0, 1'b0);
        run_op("ill",      32'hFFFF_FFFF, 32'd7,          2'b10, 32'h0000_0000, 1'b0, 1'b0);
        run_op("sra_4",    32'h8F00_0000, 32'hFFFF_FFE4,  2'b11, 32'hF8F0_0000, 1'b0, 1'b0);
        run_op("sll_inj",  32'h0000_0001, 32'd3,          2'b00, 32'h0000_0008, 1'b1, 1'b0);
        run_op("sll_fin",  32'h8000_0001, 32'd2,          2'b00, 32'h0000_0004, 1'b0, 1'b1);
        run_op("sra_pos",  32'h7000_0000, 32'd4,          2'b11, 32'h0700_0000, 1'b0, 1'b0);

        // Start while busy then flush at the shift midpoint
        @(negedge clk);
        a = 32'hF000_0000; b = 32'd16; control = 2'b11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (e = 0; e < 8; e++) begin
            start = (e == 1);
            if (e == 1) begin a = 32'h1; b = 32'd0; control = 2'b00; end
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mid busy", 32'(busy), 32'd0);
        chk("flush_mid c", c, last_c);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("flush_mid no_done", 32'(ndone), 32'd0);
        chk("flush_mid c_hold", c, last_c);
        $display("op flush_mid c=%h", c);

        // Flush during the FIN cycle (sll shamt 1: FIN is cycle 2)
        a = 32'h3; b = 32'd1; control = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_fin done", 32'(done), 32'd0);
        chk("flush_fin err", 32'(err), 32'd0);
        chk("flush_fin busy", 32'(busy), 32'd0);
        chk("flush_fin c", c, last_c);
        $display("op flush_fin c=%h", c);

        // flush and start together while idle
        a = 32'h7; b = 32'd2; control = 2'b00; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_idle busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("flush_idle no_done", 32'(ndone), 32'd0);
        $display("op flush_idle busy=%b", busy);

        // Asynchronous reset mid-shift
        a = 32'h1; b = 32'd20; control = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        chk("arst c", c, 32'h0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst err", 32'(err), 32'd0);
        #0.5;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst no_done", 32'(ndone), 32'd0);
        chk("arst busy_after", 32'(busy), 32'd0);
        $display("op arst c=%h", c);

        run_op("post_rst", 32'h0000_00FF, 32'd8, 2'b00, 32'h0000_FF00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
